// File: rtl/load_store_unit.sv
// Load/store stage: issues one data-memory access per op over req/gnt/rvalid,
// aligns load data, flags access faults and hands the result to writeback.
module load_store_unit #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned ACCESS_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_is_load,
   input  logic            in_is_store,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_addr,
   input  logic [XLEN-1:0] in_store_data,
   input  logic [4:0]      in_rd,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic [4:0]      out_rd,
   output logic            out_wb_en,
   output logic            out_fault
);

   localparam int unsigned CNT_W   = (ACCESS_TIMEOUT > 1) ? $clog2(ACCESS_TIMEOUT) : 1;
   localparam int unsigned TO_LAST = (ACCESS_TIMEOUT > 0) ? ACCESS_TIMEOUT - 1 : 0;
   localparam bit          TO_EN   = (ACCESS_TIMEOUT > 0);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RDATA, S_RESP} state_t;

   state_t            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   out_data_q, out_data_d;
   logic [4:0]        out_rd_q, out_rd_d;
   logic              out_wb_en_q, out_wb_en_d;
   logic              out_fault_q, out_fault_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;

   logic              is_mem_c, acc_fault_c, misal_c, f3_bad_c, timeout_c;
   logic [3:0]        be_c;
   logic [XLEN-1:0]   wdata_c, load_data_c;
   logic [7:0]        lbyte_c;
   logic [15:0]       lhalf_c;

   // Accept-side decode: lane enables, replicated store data and fault detection.
   always_comb begin
      is_mem_c = in_is_load | in_is_store;
      be_c     = 4'b0000;
      wdata_c  = '0;
      misal_c  = 1'b0;
      case (in_funct3[1:0])
         2'b00: begin
            be_c    = 4'b0001 << in_addr[1:0];
            wdata_c = {4{in_store_data[7:0]}};
         end
         2'b01: begin
            be_c    = in_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{in_store_data[15:0]}};
            misal_c = in_addr[0];
         end
         2'b10: begin
            be_c    = 4'b1111;
            wdata_c = in_store_data;
            misal_c = |in_addr[1:0];
         end
         default: ;
      endcase
      if (in_is_store)
         f3_bad_c = in_funct3[2] | (in_funct3[1:0] == 2'b11);
      else
         f3_bad_c = (in_funct3[1:0] == 2'b11) | (in_funct3 == 3'b110);
      acc_fault_c = (in_is_load & in_is_store) | f3_bad_c | misal_c;
   end

   // Load alignment and extension from the captured byte offset and width.
   always_comb begin
      lbyte_c = mem_rdata[{off_q, 3'b000} +: 8];
      lhalf_c = mem_rdata[{off_q[1], 4'b0000} +: 16];
      case (f3_q)
         3'b000:  load_data_c = {{(XLEN-8){lbyte_c[7]}}, lbyte_c};
         3'b001:  load_data_c = {{(XLEN-16){lhalf_c[15]}}, lhalf_c};
         3'b100:  load_data_c = {{(XLEN-8){1'b0}}, lbyte_c};
         3'b101:  load_data_c = {{(XLEN-16){1'b0}}, lhalf_c};
         default: load_data_c = mem_rdata;
      endcase
   end

   assign timeout_c = TO_EN && (cnt_q == CNT_W'(TO_LAST));

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      out_data_d  = out_data_q;
      out_rd_d    = out_rd_q;
      out_wb_en_d = out_wb_en_q;
      out_fault_d = out_fault_q;
      cnt_d       = cnt_q;
      off_d       = off_q;
      f3_d        = f3_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               off_d       = in_addr[1:0];
               f3_d        = in_funct3;
               out_rd_d    = in_rd;
               out_data_d  = '0;
               out_fault_d = 1'b0;
               out_wb_en_d = 1'b0;
               if (!is_mem_c) begin
                  out_data_d  = in_addr;
                  out_wb_en_d = (in_rd != 5'd0);
                  state_d     = S_RESP;
               end else if (acc_fault_c) begin
                  out_fault_d = 1'b1;
                  state_d     = S_RESP;
               end else begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = in_is_store;
                  mem_addr_d  = {in_addr[XLEN-1:2], 2'b00};
                  mem_be_d    = be_c;
                  mem_wdata_d = in_is_store ? wdata_c : '0;
                  out_wb_en_d = in_is_load && (in_rd != 5'd0);
                  cnt_d       = '0;
                  state_d     = S_REQ;
               end
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               state_d   = mem_we_q ? S_RESP : S_WAIT_RDATA;
            end else if (timeout_c) begin
               mem_req_d   = 1'b0;
               out_fault_d = 1'b1;
               out_wb_en_d = 1'b0;
               out_data_d  = '0;
               state_d     = S_RESP;
            end
         end
         S_WAIT_RDATA: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mem_rvalid) begin
               out_data_d = load_data_c;
               state_d    = S_RESP;
            end else if (timeout_c) begin
               out_fault_d = 1'b1;
               out_wb_en_d = 1'b0;
               out_data_d  = '0;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_RESP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= 4'b0000;
         mem_wdata_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_rd_q    <= 5'd0;
         out_wb_en_q <= 1'b0;
         out_fault_q <= 1'b0;
         cnt_q       <= '0;
         off_q       <= 2'b00;
         f3_q        <= 3'b000;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_rd_q    <= out_rd_d;
         out_wb_en_q <= out_wb_en_d;
         out_fault_q <= out_fault_d;
         cnt_q       <= cnt_d;
         off_q       <= off_d;
         f3_q        <= f3_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_rd    = out_rd_q;
   assign out_wb_en = out_wb_en_q;
   assign out_fault = out_fault_q;

endmodule
